// File: rtl/bev_pkg.sv
// Shared types and helpers for the camera-to-framebuffer write path.
// Framebuffer geometry, 3-bit pixel type and capture FSM states.
package bev_pkg;

    localparam int FB_W      = 320;
    localparam int FB_H      = 240;
    localparam int FB_ADDR_W = 17;

    typedef logic [2:0] rgb3_t;

    typedef enum logic [1:0] {
        WAIT_VS,
        VBLANK,
        ACTIVE
    } cap_state_e;

    // Keep only the MSB of each RGB565 channel.
    function automatic rgb3_t rgb565_to_rgb3(
        input logic [7:0] hi,
        input logic [7:0] lo
    );
        return {hi[7], hi[2], lo[4]};
    endfunction

endpackage

// File: rtl/cam_pixel_pair.sv
// Pairs camera bytes into RGB565 pixels and reduces them to 3-bit colour.
// Flags a line that ends on an unpaired byte.
module cam_pixel_pair
    import bev_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       strobe,
    input  logic       line_end,
    input  logic [7:0] data,
    output logic       pix_valid,
    output logic [2:0] pix_rgb3,
    output logic       pair_err
);

    logic       phase_lo;
    logic [7:0] byte1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_lo <= 1'b0;
            byte1    <= '0;
        end else if (clear || line_end) begin
            phase_lo <= 1'b0;
        end else if (strobe) begin
            if (!phase_lo) byte1 <= data;
            phase_lo <= ~phase_lo;
        end
    end

    assign pix_valid = strobe & phase_lo & ~clear;
    assign pix_rgb3  = rgb565_to_rgb3(byte1, data);
    assign pair_err  = line_end & phase_lo;

endmodule

// File: rtl/cam_frame_writer.sv
// Captures a camera RGB565 stream, decimates 2:1 in X and Y and
// writes 3-bit pixels into the framebuffer with frame status pulses.
module cam_frame_writer
    import bev_pkg::*;
#(
    parameter int SRC_W  = 2 * FB_W,
    parameter int SRC_H  = 2 * FB_H,
    parameter int DST_W  = FB_W,
    parameter int DST_H  = FB_H,
    parameter int ADDR_W = FB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture_en,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic              cam_pclk_en,
    input  logic [7:0]        cam_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [2:0]        wr_data,
    output logic              frame_done,
    output logic              frame_err
);

    localparam int XW = $clog2(SRC_W + 1);
    localparam int YW = $clog2(SRC_H + 1);
    localparam logic [XW-1:0]     X_LIM  = XW'(SRC_W);
    localparam logic [YW-1:0]     Y_LIM  = YW'(SRC_H);
    localparam logic [ADDR_W:0]   A_MAX  = (ADDR_W+1)'(DST_W * DST_H - 1);
    localparam logic [ADDR_W-1:0] A_STEP = ADDR_W'(DST_W);

    cap_state_e        state;
    logic              vs_q;
    logic              href_q;
    logic [XW-1:0]     src_x;
    logic [YW-1:0]     src_y;
    logic [ADDR_W-1:0] line_base;
    logic              line_err;

    logic              active;
    logic              vs_rise;
    logic              vs_fall;
    logic              line_end;
    logic              strobe;
    logic              pix_valid;
    logic [2:0]        pix_rgb3;
    logic              pair_err;
    logic              keep;
    logic [ADDR_W:0]   pix_addr;

    assign active   = (state == ACTIVE);
    assign vs_rise  = cam_vsync & ~vs_q;
    assign vs_fall  = ~cam_vsync & vs_q;
    assign line_end = active & href_q & ~cam_href;
    // vsync rising wins over a byte arriving in the same cycle
    assign strobe   = active & cam_href & cam_pclk_en & ~vs_rise;

    assign keep = ~src_x[0] & ~src_y[0]
                & (src_x < X_LIM) & (src_y < Y_LIM);
    assign pix_addr = {1'b0, line_base}
                    + (ADDR_W+1)'(src_x >> 1);

    cam_pixel_pair u_pair (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (~active),
        .strobe    (strobe),
        .line_end  (line_end),
        .data      (cam_data),
        .pix_valid (pix_valid),
        .pix_rgb3  (pix_rgb3),
        .pair_err  (pair_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WAIT_VS;
            vs_q       <= 1'b0;
            href_q     <= 1'b0;
            src_x      <= '0;
            src_y      <= '0;
            line_base  <= '0;
            line_err   <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            vs_q       <= cam_vsync;
            href_q     <= cam_href;
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            unique case (state)
                WAIT_VS: begin
                    if (cam_vsync) state <= VBLANK;
                end
                VBLANK: begin
                    if (vs_fall && capture_en) begin
                        state     <= ACTIVE;
                        src_x     <= '0;
                        src_y     <= '0;
                        line_base <= '0;
                        line_err  <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (vs_rise) begin
                        state <= VBLANK;
                        if (src_y == Y_LIM && !line_err)
                            frame_done <= 1'b1;
                        else
                            frame_err <= 1'b1;
                    end else begin
                        if (pix_valid) begin
                            if (src_x < X_LIM) src_x <= src_x + 1'b1;
                            if (keep && pix_addr <= A_MAX) begin
                                wr_en   <= 1'b1;
                                wr_addr <= pix_addr[ADDR_W-1:0];
                                wr_data <= pix_rgb3;
                            end
                        end
                        if (line_end) begin
                            src_x <= '0;
                            if (src_y < Y_LIM) begin
                                src_y <= src_y + 1'b1;
                                if (!src_y[0])
                                    line_base <= line_base + A_STEP;
                                // short lines and dangling bytes spoil the frame
                                if (src_x < X_LIM || pair_err)
                                    line_err <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= WAIT_VS;
            endcase
        end
    end

endmodule
